// File: rtl/reg_file_sb.sv
// Integer register file with per-register pending-write scoreboard.
// Combinational read ports with write bypass; saturating in-flight counters drive RAW stalls.
module reg_file_sb #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned NRD  = 2,
  parameter int unsigned AW   = 5,
  parameter int unsigned CNTW = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en_i,
  input  logic [AW-1:0]       wr_addr_i,
  input  logic [XLEN-1:0]     wr_data_i,
  input  logic                issue_valid_i,
  input  logic [AW-1:0]       issue_rd_i,
  output logic                issue_ready_o,
  input  logic                flush_i,
  input  logic [NRD-1:0]      rd_req_i,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o
);

  localparam logic [AW:0]     NregW  = (AW+1)'(NREG);
  localparam logic [CNTW-1:0] CntMax = '1;

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [CNTW-1:0] cnt_q  [NREG];
  logic [CNTW-1:0] cnt_d  [NREG];

  // x0 and out-of-range addresses are inert for every operation.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < NregW);
  endfunction

  logic wr_ok, iss_ok, issue_fire;

  always_comb begin
    wr_ok  = wr_en_i && addr_ok(wr_addr_i);
    iss_ok = addr_ok(issue_rd_i);
    issue_ready_o = 1'b0;
    if (rst && !flush_i) begin
      if (!iss_ok) begin
        issue_ready_o = 1'b1;
      end else begin
        issue_ready_o = (cnt_q[issue_rd_i] != CntMax) ||
                        (wr_en_i && (wr_addr_i == issue_rd_i));
      end
    end
    issue_fire = issue_valid_i && issue_ready_o && iss_ok;
  end

  always_comb begin
    regs_d[0] = '0;
    cnt_d[0]  = '0;
    for (int i = 1; i < NREG; i++) begin
      logic wr_hit, is_hit;
      wr_hit    = wr_ok && (wr_addr_i == AW'(i));
      is_hit    = issue_fire && (issue_rd_i == AW'(i));
      regs_d[i] = wr_hit ? wr_data_i : regs_q[i];
      cnt_d[i]  = cnt_q[i];
      if (flush_i) begin
        cnt_d[i] = '0;
      end else if (is_hit && wr_hit) begin
        // Retire and re-mark cancel out; an untracked write still leaves one pending.
        if (cnt_q[i] == '0) cnt_d[i] = CNTW'(1);
      end else if (is_hit) begin
        cnt_d[i] = cnt_q[i] + CNTW'(1);
      end else if (wr_hit && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (!rst) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end else begin
        regs_q[i] <= regs_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int p = 0; p < NRD; p++) begin
      logic [AW-1:0]   a;
      logic [CNTW-1:0] c;
      logic            byp;
      a   = rd_addr_i[p*AW +: AW];
      c   = '0;
      byp = 1'b0;
      if (rst && rd_req_i[p] && addr_ok(a)) begin
        c   = cnt_q[a];
        byp = wr_en_i && (wr_addr_i == a);
        rd_data_o[p*XLEN +: XLEN] = byp ? wr_data_i : regs_q[a];
        rd_busy_o[p] = (c - CNTW'(byp && (c != '0))) != '0;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: reset, bypass, scoreboard saturation, flush, reset mid-op.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        flush;
  logic [1:0]  rd_req;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;

  int checks = 0;
  int failures = 0;

  reg_file_sb dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en_i       (wr_en),
    .wr_addr_i     (wr_addr),
    .wr_data_i     (wr_data),
    .issue_valid_i (issue_valid),
    .issue_rd_i    (issue_rd),
    .issue_ready_o (issue_ready),
    .flush_i       (flush),
    .rd_req_i      (rd_req),
    .rd_addr_i     (rd_addr),
    .rd_data_o     (rd_data),
    .rd_busy_o     (rd_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd2(input logic [4:0] a0, input logic [4:0] a1);
    rd_req  = 2'b11;
    rd_addr = {a1, a0};
    #1;
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    issue_valid = 1'b0; issue_rd = 5'd1; flush = 1'b0;
    rd_req = '0; rd_addr = '0;

    // 1 Reset
    tick();
    rd2(5'd5, 5'd6);
    check("ready_in_reset", {31'b0, issue_ready}, 32'd0);
    check("data_in_reset", rd_data[31:0], 32'd0);
    tick();
    rst = 1'b1;
    #1;
    check("ready_after_reset", {31'b0, issue_ready}, 32'd1);
    for (int i = 1; i < 32; i++) begin
      rd2(5'(i), 5'(i));
      check("rst_data0", rd_data[31:0], 32'd0);
      check("rst_data1", rd_data[63:32], 32'd0);
      check("rst_busy", {30'b0, rd_busy}, 32'd0);
    end

    // 2 Write then read, x0 stays zero
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    tick();
    wr_en = 1'b0;
    rd2(5'd5, 5'd0);
    check("wr_x5", rd_data[31:0], 32'hDEADBEEF);
    check("wr_x5_busy", {31'b0, rd_busy[0]}, 32'd0);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
    rd2(5'd0, 5'd0);
    check("x0_bypass", rd_data[31:0], 32'd0);
    tick();
    wr_en = 1'b0;
    rd2(5'd0, 5'd5);
    check("x0_read", rd_data[31:0], 32'd0);
    check("x5_kept", rd_data[63:32], 32'hDEADBEEF);

    // 3 Bypass on both ports
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
    rd2(5'd7, 5'd7);
    check("byp_p0", rd_data[31:0], 32'hA5A5A5A5);
    check("byp_p1", rd_data[63:32], 32'hA5A5A5A5);
    tick();
    wr_en = 1'b0;

    // 4 Scoreboard saturation on x3
    issue_valid = 1'b1; issue_rd = 5'd3;
    #1;
    check("iss3_ready0", {31'b0, issue_ready}, 32'd1);
    tick(); tick(); tick();
    issue_valid = 1'b0;
    rd2(5'd3, 5'd3);
    check("iss3_sat_ready", {31'b0, issue_ready}, 32'd0);
    check("iss3_busy", {30'b0, rd_busy}, 32'd3);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33; issue_valid = 1'b1;
    #1;
    check("wr_iss3_ready", {31'b0, issue_ready}, 32'd1);
    check("wr_iss3_busy", {31'b0, rd_busy[0]}, 32'd1);
    check("wr_iss3_data", rd_data[31:0], 32'h33);
    tick();
    wr_en = 1'b0; issue_valid = 1'b0;
    #1;
    check("cnt3_still_max", {31'b0, issue_ready}, 32'd0);
    wr_en = 1'b1; wr_data = 32'h31;
    #1;
    check("drain1_busy", {31'b0, rd_busy[0]}, 32'd1);
    tick();
    wr_data = 32'h32;
    #1;
    check("drain2_busy", {31'b0, rd_busy[0]}, 32'd1);
    tick();
    wr_data = 32'h35;
    #1;
    check("drain3_busy", {31'b0, rd_busy[0]}, 32'd0);
    check("drain3_data", rd_data[31:0], 32'h35);
    tick();
    wr_en = 1'b0;
    #1;
    check("x3_after_busy", {30'b0, rd_busy}, 32'd0);
    check("x3_after_data", rd_data[63:32], 32'h35);
    wr_en = 1'b1; wr_data = 32'h36;
    tick();
    wr_en = 1'b0;
    #1;
    check("no_underflow_ready", {31'b0, issue_ready}, 32'd1);
    check("no_underflow_busy", {30'b0, rd_busy}, 32'd0);

    // Same-cycle write+issue at cnt 0 leaves one pending
    wr_en = 1'b1; wr_addr = 5'd11; wr_data = 32'hB0B; issue_valid = 1'b1; issue_rd = 5'd11;
    tick();
    wr_en = 1'b0; issue_valid = 1'b0;
    rd2(5'd11, 5'd0);
    check("x11_busy", {31'b0, rd_busy[0]}, 32'd1);
    check("x11_data", rd_data[31:0], 32'hB0B);

    // 5 Flush
    issue_valid = 1'b1; issue_rd = 5'd4;
    tick();
    issue_rd = 5'd9;
    tick();
    issue_valid = 1'b0;
    rd2(5'd4, 5'd9);
    check("pre_flush_busy", {30'b0, rd_busy}, 32'd3);
    flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd10;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
    #1;
    check("flush_ready", {31'b0, issue_ready}, 32'd0);
    tick();
    flush = 1'b0; issue_valid = 1'b0; wr_en = 1'b0;
    rd2(5'd4, 5'd9);
    check("flush_busy_4_9", {30'b0, rd_busy}, 32'd0);
    check("flush_x9_data", rd_data[63:32], 32'h55);
    rd2(5'd10, 5'd11);
    check("flush_busy_10_11", {30'b0, rd_busy}, 32'd0);

    // 6 Reset mid-operation
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h77;
    tick();
    wr_en = 1'b0; issue_valid = 1'b1; issue_rd = 5'd2;
    tick(); tick();
    issue_valid = 1'b0;
    rd2(5'd2, 5'd2);
    check("pre_rst_busy", {30'b0, rd_busy}, 32'd3);
    check("pre_rst_data", rd_data[31:0], 32'h77);
    rst = 1'b0; wr_en = 1'b1; wr_data = 32'hFFFF; issue_valid = 1'b1;
    #1;
    check("midrst_data", rd_data[31:0], 32'd0);
    check("midrst_ready", {31'b0, issue_ready}, 32'd0);
    tick();
    rst = 1'b1; wr_en = 1'b0; issue_valid = 1'b0;
    rd2(5'd2, 5'd7);
    check("post_rst_x2", rd_data[31:0], 32'd0);
    check("post_rst_x7", rd_data[63:32], 32'd0);
    check("post_rst_busy", {30'b0, rd_busy}, 32'd0);
    check("post_rst_ready", {31'b0, issue_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
